deadlock_stall_detector: RTL and testbench
==========================================

Name: deadlock_stall_detector

Overview:
- Per-kernel deadlock detection stage. Consumes the per-channel AXIS block vector, per-instance idle vector and per-instance block vector gathered by the kernel monitor top.
- Asserts a sticky block flag once the combined block pattern has stayed non-empty and unchanged for THRESH consecutive cycles while at least one monitored instance is active.
- Also freezes a diagnostic snapshot: the pattern, the lowest blocked AXIS index and the stall length, for the simulation bench to report.

Parameters:
- NUM_AXIS, 14, number of AXIS channel block bits.
- NUM_INST, 3, number of instance idle bits.
- NUM_IBLK, 1, number of instance block bits.
- IDLE_MASK, 3'b110, instances whose idle bit counts toward "kernel finished". Bits at 0 are ignored.
- THRESH, 64, consecutive identical stalled cycles required to declare deadlock. Must be ≥2.
- CNT_W, 16, width of the stall cycle counter. Must satisfy 2^CNT_W > THRESH.

Ports:
- clock  in  1  monitor clock.
- reset  in  1  synchronous, active-high reset.
- axis_block_sigs  in  NUM_AXIS  1 = channel blocked this cycle.
- inst_idle_sigs  in  NUM_INST  1 = instance idle.
- inst_block_sigs  in  NUM_IBLK  1 = instance blocked.
- block  out  1  sticky deadlock flag.
- stall_active  out  1  currently in WATCH state.
- snap_axis  out  NUM_AXIS  AXIS pattern captured at declaration.
- snap_iblk  out  NUM_IBLK  instance-block pattern captured at declaration.
- first_axis_idx  out  $clog2(NUM_AXIS+1)  lowest set bit of snap_axis; NUM_AXIS if snap_axis==0.
- stall_cycles  out  CNT_W  consecutive identical-stall count; saturates at all-ones.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - block=0, stall_active=0.
  - snap_axis=0, snap_iblk=0.
  - first_axis_idx=0, stall_cycles=0.
  - state=IDLE, internal pattern register=0.
- Combinational terms:
  - all_idle = &(inst_idle_sigs | ~IDLE_MASK).
  - pat = {inst_block_sigs, axis_block_sigs}.
  - candidate = (|pat) & ~all_idle.
- FSM, all registered:
  - IDLE: if candidate, capture pat, cnt←1, go to WATCH. Otherwise cnt←0.
  - WATCH, evaluated in priority order:
    - !candidate → IDLE, cnt←0.
    - pat != captured → recapture pat, cnt←1, stay (progress observed).
    - Otherwise cnt←cnt+1, saturating.
    - When the incremented value equals THRESH → BLOCKED in the same edge. block←1. snap_axis/snap_iblk←captured. first_axis_idx←priority encode of captured axis bits.
  - BLOCKED: terminal. block, snap_* and first_axis_idx hold. stall_cycles keeps counting (saturating) while pat==captured and is frozen otherwise. Inputs are otherwise ignored. Exit only via reset.
- Outputs:
  - stall_active = (state==WATCH), registered.
  - stall_cycles mirrors cnt.
- Latency: if candidate and an identical pat are sampled on edges t..t+THRESH-1, block is high immediately after edge t+THRESH-1. That is THRESH sampled cycles, with no extra pipeline stage.
- Boundary conditions:
  - all_idle asserting mid-WATCH → IDLE on that edge. No deadlock is declared.
  - pat changes on the exact edge where cnt would reach THRESH → recapture wins, cnt←1, no block.
  - Only inst_block bits set → still a candidate; first_axis_idx=NUM_AXIS at declaration.
  - reset asserted in any state, including BLOCKED → all outputs return to reset values on that edge. reset has priority over every transition.
  - cnt saturation: stall_cycles stops at 2^CNT_W-1 and never wraps.

Decomposition:
- Shared package deadlock_mon_pkg holds:
  - state enum {IDLE, WATCH, BLOCKED}.
  - default parameter constants (NUM_AXIS, NUM_INST, NUM_IBLK, THRESH).
  - a function computing the index width.
- One natural sub-module: deadlock_prio_enc, a parameterised lowest-set-bit encoder that returns NUM_AXIS when the input is zero. Used for first_axis_idx.

Test Plan:
Directed scenarios use THRESH=8 and IDLE_MASK=3'b110.
1. Reset, then axis_block_sigs=14'h0010 with inst_idle_sigs=3'b000 held for 8 cycles → block=1 right after the 8th edge; snap_axis=14'h0010; first_axis_idx=4; stall_cycles=8.
2. Same stimulus for 5 cycles, then change to 14'h0011 for 8 more cycles → no block at cycle 8; block rises after edge 13; snap_axis=14'h0011; first_axis_idx=0.
3. axis_block_sigs=14'h2000 for 6 cycles, then inst_idle_sigs=3'b110 → returns to IDLE, block stays 0, stall_active drops on that edge.
4. axis_block_sigs=0 and inst_block_sigs=1 for 8 cycles → block=1, snap_iblk=1, first_axis_idx=14.
5. Reach BLOCKED, then assert reset for 1 cycle → every output is 0 after that edge; a fresh 8-cycle stall re-declares correctly.
6. Pattern toggles on the exact 8th edge → block stays 0, stall_cycles=1.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : deadlock_mon_pkg
// Purpose : Shared types and default constants for the per-kernel deadlock
//           detection stage (state enum, default sizes, index-width helper).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    BLOCKED = 2'd2
  } det_state_e;

  localparam int DEF_NUM_AXIS = 14;
  localparam int DEF_NUM_INST = 3;
  localparam int DEF_NUM_IBLK = 1;
  localparam int DEF_THRESH   = 64;
  localparam int DEF_CNT_W    = 16;

  // Width needed to hold an index 0..n inclusive (n is the "no bit set" code).
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deadlock_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : deadlock_prio_enc
// Purpose : Lowest-set-bit encoder. Returns WIDTH when the input is all zero.
// Ports   : i_vec  [WIDTH-1:0]  input vector
//           o_idx  [IDX_W-1:0]  index of lowest set bit, or WIDTH if none
// Rev     : 1.0  initial release
// ============================================================================
module deadlock_prio_enc #(
  parameter int WIDTH = 14,
  parameter int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    o_idx = IDX_W'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/deadlock_stall_detector.sv
`default_nettype none
// ============================================================================
// Module  : deadlock_stall_detector
// Purpose : Declares a sticky deadlock once the combined AXIS/instance block
//           pattern stays non-empty and unchanged for THRESH consecutive
//           cycles while the kernel is not finished. Freezes a snapshot of
//           the offending pattern for diagnostic reporting.
// Ports   : clock, reset                  clock, sync active-high reset
//           axis_block_sigs [NUM_AXIS]    per-channel blocked flags
//           inst_idle_sigs  [NUM_INST]    per-instance idle flags
//           inst_block_sigs [NUM_IBLK]    per-instance blocked flags
//           block                         sticky deadlock flag
//           stall_active                  watching a candidate stall
//           snap_axis / snap_iblk         pattern captured at declaration
//           first_axis_idx                lowest blocked channel in snapshot
//           stall_cycles    [CNT_W]       identical-stall length (saturating)
// Rev     : 1.0  initial release
// ============================================================================
module deadlock_stall_detector
  import deadlock_mon_pkg::*;
#(
  parameter int                  NUM_AXIS  = DEF_NUM_AXIS,
  parameter int                  NUM_INST  = DEF_NUM_INST,
  parameter int                  NUM_IBLK  = DEF_NUM_IBLK,
  parameter logic [NUM_INST-1:0] IDLE_MASK = 3'b110,
  parameter int                  THRESH    = DEF_THRESH,
  parameter int                  CNT_W     = DEF_CNT_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_AXIS-1:0]            axis_block_sigs,
  input  logic [NUM_INST-1:0]            inst_idle_sigs,
  input  logic [NUM_IBLK-1:0]            inst_block_sigs,
  output logic                           block,
  output logic                           stall_active,
  output logic [NUM_AXIS-1:0]            snap_axis,
  output logic [NUM_IBLK-1:0]            snap_iblk,
  output logic [idx_width(NUM_AXIS)-1:0] first_axis_idx,
  output logic [CNT_W-1:0]               stall_cycles
);

  localparam int               PAT_W      = NUM_AXIS + NUM_IBLK;
  localparam int               IDX_W      = idx_width(NUM_AXIS);
  localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  det_state_e          state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                block_q, block_d;
  logic [NUM_AXIS-1:0] snap_axis_q, snap_axis_d;
  logic [NUM_IBLK-1:0] snap_iblk_q, snap_iblk_d;
  logic [IDX_W-1:0]    first_idx_q, first_idx_d;

  logic                all_idle;
  logic                candidate;
  logic [PAT_W-1:0]    pat;
  logic [CNT_W-1:0]    cnt_inc;
  logic [IDX_W-1:0]    enc_idx;

  // Instances masked out of IDLE_MASK are treated as permanently idle.
  assign all_idle  = &(inst_idle_sigs | ~IDLE_MASK);
  assign pat       = {inst_block_sigs, axis_block_sigs};
  assign candidate = (|pat) & ~all_idle;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Encodes the captured pattern; it equals the pattern being frozen on the
  // declaring edge because declaration only happens when pat == pat_q.
  deadlock_prio_enc #(
    .WIDTH (NUM_AXIS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_vec (pat_q[NUM_AXIS-1:0]),
    .o_idx (enc_idx)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    block_d     = block_q;
    snap_axis_d = snap_axis_q;
    snap_iblk_d = snap_iblk_q;
    first_idx_d = first_idx_q;

    unique case (state_q)
      IDLE: begin
        if (candidate) begin
          pat_d   = pat;
          cnt_d   = CNT_W'(1);
          state_d = WATCH;
        end else begin
          cnt_d   = '0;
        end
      end

      WATCH: begin
        if (!candidate) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (pat != pat_q) begin
          // Progress observed: restart the run on the new pattern.
          pat_d   = pat;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == THRESH_CNT) begin
            state_d     = BLOCKED;
            block_d     = 1'b1;
            snap_axis_d = pat_q[NUM_AXIS-1:0];
            snap_iblk_d = pat_q[PAT_W-1:NUM_AXIS];
            first_idx_d = enc_idx;
          end
        end
      end

      BLOCKED: begin
        // Terminal: only the stall length keeps tracking the frozen pattern.
        if (pat == pat_q) begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      cnt_q       <= '0;
      block_q     <= 1'b0;
      snap_axis_q <= '0;
      snap_iblk_q <= '0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      snap_axis_q <= snap_axis_d;
      snap_iblk_q <= snap_iblk_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign block          = block_q;
  assign stall_active   = (state_q == WATCH);
  assign snap_axis      = snap_axis_q;
  assign snap_iblk      = snap_iblk_q;
  assign first_axis_idx = first_idx_q;
  assign stall_cycles   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_deadlock_stall_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_deadlock_stall_detector
// Purpose : Self-checking bench: a table of directed vectors with hand-derived
//           expectations, then random segments checked against a history-based
//           reference model of the deadlock rules.
// Ports   : none (testbench)
// Rev     : 1.0  initial release
// ============================================================================
module tb_deadlock_stall_detector;

  localparam int         NA   = 14;
  localparam int         TH   = 8;
  localparam int         CW   = 4;
  localparam int         SAT  = 15;
  localparam logic [2:0] MASK = 3'b110;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [13:0]   axis_block_sigs = '0;
  logic [2:0]    inst_idle_sigs  = '0;
  logic [0:0]    inst_block_sigs = '0;
  logic          block;
  logic          stall_active;
  logic [13:0]   snap_axis;
  logic [0:0]    snap_iblk;
  logic [3:0]    first_axis_idx;
  logic [CW-1:0] stall_cycles;

  always #5 clock = ~clock;

  deadlock_stall_detector #(
    .NUM_AXIS  (NA),
    .NUM_INST  (3),
    .NUM_IBLK  (1),
    .IDLE_MASK (MASK),
    .THRESH    (TH),
    .CNT_W     (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block),
    .stall_active    (stall_active),
    .snap_axis       (snap_axis),
    .snap_iblk       (snap_iblk),
    .first_axis_idx  (first_axis_idx),
    .stall_cycles    (stall_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    logic [13:0] axis;
    logic [2:0]  idle;
    logic        iblk;
    logic        e_block;
    logic        e_act;
    logic [3:0]  e_cnt;
    logic [13:0] e_sa;
    logic        e_si;
    logic [3:0]  e_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic [13:0] a, input logic [2:0] idl, input logic ib,
                     input logic eb, input logic ea, input int ec,
                     input logic [13:0] esa, input logic esi, input int eidx);
    vec_t v;
    v.rst = rst; v.axis = a; v.idle = idl; v.iblk = ib;
    v.e_block = eb; v.e_act = ea; v.e_cnt = 4'(ec);
    v.e_sa = esa; v.e_si = esi; v.e_idx = 4'(eidx);
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Keeps the recent sample history and derives the run length of identical
  // candidate patterns by scanning it backwards.
  logic [14:0] hist_pat[$];
  bit          hist_cand[$];
  bit          m_decl;
  logic [14:0] m_snap;
  int          m_after;
  int          m_run;

  function automatic int lowest(input logic [13:0] v);
    for (int i = 0; i < NA; i++) if (v[i]) return i;
    return NA;
  endfunction

  task automatic model_update(input bit rst, input logic [13:0] a, input logic [2:0] idl, input logic ib);
    logic [14:0] p;
    bit          cand;
    p    = {ib, a};
    cand = (p != 15'd0) && ((idl | ~MASK) != 3'b111);
    if (rst) begin
      hist_pat.delete(); hist_cand.delete();
      m_decl = 0; m_snap = '0; m_after = 0; m_run = 0;
      return;
    end
    if (m_decl) begin
      if (p == m_snap) m_after++;
      return;
    end
    hist_pat.push_back(p);
    hist_cand.push_back(cand);
    if (hist_pat.size() > TH) begin
      void'(hist_pat.pop_front());
      void'(hist_cand.pop_front());
    end
    m_run = 0;
    for (int i = hist_pat.size() - 1; i >= 0; i--) begin
      if (hist_cand[i] && hist_pat[i] == p) m_run++;
      else break;
    end
    if (m_run == TH) begin
      m_decl = 1; m_snap = p; m_after = 0;
    end
  endtask

  task automatic apply(input bit rst, input logic [13:0] a, input logic [2:0] idl, input logic ib);
    reset           = rst;
    axis_block_sigs = a;
    inst_idle_sigs  = idl;
    inst_block_sigs = ib;
    @(posedge clock);
    #1;
    model_update(rst, a, idl, ib);
  endtask

  task automatic check_model(input int step);
    int exp_cnt;
    exp_cnt = m_decl ? ((TH + m_after > SAT) ? SAT : TH + m_after) : m_run;
    chk("rnd_block",  step, 32'(block),          32'(m_decl));
    chk("rnd_active", step, 32'(stall_active),   32'(!m_decl && m_run > 0));
    chk("rnd_cnt",    step, 32'(stall_cycles),   32'(exp_cnt));
    chk("rnd_saxis",  step, 32'(snap_axis),      m_decl ? 32'(m_snap[13:0]) : 32'd0);
    chk("rnd_siblk",  step, 32'(snap_iblk),      m_decl ? 32'(m_snap[14])   : 32'd0);
    chk("rnd_idx",    step, 32'(first_axis_idx), m_decl ? 32'(lowest(m_snap[13:0])) : 32'd0);
  endtask

  logic [13:0] r_axis;
  logic [2:0]  r_idle;
  logic        r_iblk;
  bit          r_rst;
  int          r_len;
  int          step_no;

  initial begin
    // Test 1: single channel stalled for THRESH cycles.
    add(1, 14'h0, 3'b000, 0, 0, 0, 0, 14'h0, 0, 0);
    for (int k = 1; k < TH; k++) add(0, 14'h0010, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h0010, 3'b000, 0, 1, 0, 8, 14'h0010, 0, 4);
    // Test 5: reset out of BLOCKED (inputs still stalled), then re-declare.
    add(1, 14'h0010, 3'b000, 0, 0, 0, 0, 14'h0, 0, 0);
    for (int k = 1; k < TH; k++) add(0, 14'h0010, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h0010, 3'b000, 0, 1, 0, 8, 14'h0010, 0, 4);
    // Test 2: progress after 5 cycles restarts the run.
    add(1, 14'h0, 3'b000, 0, 0, 0, 0, 14'h0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 14'h0010, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    for (int k = 1; k < TH; k++) add(0, 14'h0011, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h0011, 3'b000, 0, 1, 0, 8, 14'h0011, 0, 0);
    // Test 3: kernel finishes mid-watch; masked idle bit alone does not count.
    add(1, 14'h0, 3'b000, 0, 0, 0, 0, 14'h0, 0, 0);
    for (int k = 1; k <= 6; k++) add(0, 14'h2000, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h2000, 3'b110, 0, 0, 0, 0, 14'h0, 0, 0);
    add(0, 14'h2000, 3'b110, 0, 0, 0, 0, 14'h0, 0, 0);
    add(0, 14'h2000, 3'b011, 0, 0, 1, 1, 14'h0, 0, 0);
    // Test 4: instance-block only; then BLOCKED counting, freezing, saturation.
    add(1, 14'h0, 3'b000, 0, 0, 0, 0, 14'h0, 0, 0);
    for (int k = 1; k < TH; k++) add(0, 14'h0, 3'b000, 1, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h0,    3'b000, 1, 1, 0, 8,  14'h0, 1, 14);
    add(0, 14'h0001, 3'b000, 1, 1, 0, 8,  14'h0, 1, 14);
    add(0, 14'h0,    3'b111, 1, 1, 0, 9,  14'h0, 1, 14);
    for (int k = 10; k <= 15; k++) add(0, 14'h0, 3'b000, 1, 1, 0, k, 14'h0, 1, 14);
    add(0, 14'h0, 3'b000, 1, 1, 0, 15, 14'h0, 1, 14);
    add(0, 14'h0, 3'b000, 1, 1, 0, 15, 14'h0, 1, 14);
    // Test 6: pattern changes on the edge that would have declared.
    add(1, 14'h0, 3'b000, 0, 0, 0, 0, 14'h0, 0, 0);
    for (int k = 1; k < TH; k++) add(0, 14'h0010, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h0100, 3'b000, 0, 0, 1, 1, 14'h0, 0, 0);
    for (int k = 2; k < TH; k++) add(0, 14'h0100, 3'b000, 0, 0, 1, k, 14'h0, 0, 0);
    add(0, 14'h0100, 3'b000, 0, 1, 0, 8, 14'h0100, 0, 8);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].axis, vecs[i].idle, vecs[i].iblk);
      chk("tbl_block",  i, 32'(block),          32'(vecs[i].e_block));
      chk("tbl_active", i, 32'(stall_active),   32'(vecs[i].e_act));
      chk("tbl_cnt",    i, 32'(stall_cycles),   32'(vecs[i].e_cnt));
      chk("tbl_saxis",  i, 32'(snap_axis),      32'(vecs[i].e_sa));
      chk("tbl_siblk",  i, 32'(snap_iblk),      32'(vecs[i].e_si));
      chk("tbl_idx",    i, 32'(first_axis_idx), 32'(vecs[i].e_idx));
    end

    // Random segments: each holds one input pattern for a random length.
    apply(1, 14'h0, 3'b000, 0);
    step_no = 0;
    for (int s = 0; s < 160; s++) begin
      r_rst = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 3))
        0:       r_axis = 14'h0;
        1:       r_axis = 14'h0001 << $urandom_range(0, 13);
        default: r_axis = 14'($urandom);
      endcase
      r_idle = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      r_iblk = ($urandom_range(0, 3) == 0);
      r_len  = $urandom_range(1, 12);
      for (int c = 0; c < r_len; c++) begin
        apply(r_rst && (c == 0), r_axis, r_idle, r_iblk);
        check_model(step_no);
        step_no++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
